// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the 16-bit core: sequences FETCH/DECODE/EXEC/MEM/WB from the
// IR opcode, drives the datapath strobes and runs the shared memory-port handshake.
module multicycle_control_fsm #(
   parameter int         MEM_TIMEOUT = 16,
   parameter logic [3:0] HALT_OP     = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [2:0]  alu_op,
   output logic        alu_src_b,
   output logic [1:0]  imm_src,
   output logic        reg_write,
   output logic [1:0]  wb_src,
   output logic        halted,
   output logic        fault
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_SHIFT = 4'b0101;
   localparam logic [3:0] OP_LOAD  = 4'b0110;
   localparam logic [3:0] OP_STORE = 4'b0111;
   localparam logic [3:0] OP_BEQ   = 4'b1000;
   localparam logic [3:0] OP_BNE   = 4'b1001;
   localparam logic [3:0] OP_LDI   = 4'b1010;
   localparam logic [3:0] OP_JMP   = 4'b1101;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SHL = 3'b100;
   localparam logic [2:0] ALU_SHR = 3'b101;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [3:0]    opcode_s;
   logic [1:0]    imm_sel_s;
   logic          timeout_s;
   logic          taken_s;
   logic          unused_instr_s;

   function automatic logic [1:0] imm_of(input logic [3:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_BEQ, OP_BNE: imm_of = 2'b01;
         OP_SHIFT:                          imm_of = 2'b10;
         OP_ADDI:                           imm_of = 2'b11;
         default:                           imm_of = 2'b00;
      endcase
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SHIFT,
         OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_LDI, OP_JMP: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   endfunction

   assign opcode_s       = instr[15:12];
   assign imm_sel_s      = imm_of(opcode_s);
   assign timeout_s      = (MEM_TIMEOUT != 0) && (cnt_r == TO_LAST);
   assign taken_s        = ((opcode_s == OP_BEQ) & zero) | ((opcode_s == OP_BNE) & ~zero);
   assign unused_instr_s = ^instr[10:0];

   // State sequencing, memory wait counter and the sticky halted/fault flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_RESET;
         cnt_r   <= '0;
         halted  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         cnt_r <= '0;
         case (state_r)
            S_RESET: state_r <= S_FETCH;
            S_FETCH, S_MEM: begin
               if (mem_ready) begin
                  if (state_r == S_FETCH) state_r <= S_DECODE;
                  else if (opcode_s == OP_LOAD) state_r <= S_WB;
                  else state_r <= S_FETCH;
               end else if (timeout_s) begin
                  state_r <= S_HALT;
                  halted  <= 1'b1;
                  fault   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            S_DECODE: begin
               if (opcode_s == HALT_OP) begin
                  state_r <= S_HALT;
                  halted  <= 1'b1;
               end else if (!is_legal(opcode_s)) begin
                  state_r <= S_HALT;
                  halted  <= 1'b1;
                  fault   <= 1'b1;
               end else begin
                  state_r <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (opcode_s)
                  OP_LOAD, OP_STORE:     state_r <= S_MEM;
                  OP_BEQ, OP_BNE, OP_JMP: state_r <= S_FETCH;
                  default:               state_r <= S_WB;
               endcase
            end
            S_WB:    state_r <= S_FETCH;
            S_HALT:  state_r <= S_HALT;
            default: state_r <= S_RESET;
         endcase
      end
   end

   // Datapath strobes decoded from the current state and opcode; the fetch-complete
   // strobes are qualified by mem_ready so IR and PC load in the handshake cycle.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_src  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_op    = ALU_ADD;
      alu_src_b = 1'b0;
      imm_src   = 2'b00;
      reg_write = 1'b0;
      wb_src    = 2'b00;
      case (state_r)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end else begin
               ir_write = 1'b0;
               pc_write = 1'b0;
            end
         end
         S_DECODE: imm_src = imm_sel_s;
         S_EXEC: begin
            imm_src = imm_sel_s;
            case (opcode_s)
               OP_SUB: alu_op = ALU_SUB;
               OP_AND: alu_op = ALU_AND;
               OP_OR:  alu_op = ALU_OR;
               OP_ADDI, OP_LOAD, OP_STORE: alu_src_b = 1'b1;
               OP_SHIFT: begin
                  alu_op    = instr[11] ? ALU_SHR : ALU_SHL;
                  alu_src_b = 1'b1;
               end
               OP_BEQ, OP_BNE: begin
                  alu_op = ALU_SUB;
                  if (taken_s) begin
                     pc_write = 1'b1;
                     pc_src   = 2'b01;
                  end else begin
                     pc_write = 1'b0;
                     pc_src   = 2'b00;
                  end
               end
               OP_JMP: begin
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
               end
               default: alu_op = ALU_ADD;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
            mem_we   = (opcode_s == OP_STORE);
            imm_src  = imm_sel_s;
         end
         S_WB: begin
            reg_write = 1'b1;
            imm_src   = imm_sel_s;
            if (opcode_s == OP_LOAD) wb_src = 2'b01;
            else if (opcode_s == OP_LDI) wb_src = 2'b10;
            else wb_src = 2'b00;
         end
         default: mem_req = 1'b0;
      endcase
   end

endmodule
